// File: rtl/fetch_decode_pipe.sv
// ---------------------------------------------------------------------------
// fetch_decode_pipe
//
// Front-end register bank of the 5-stage MIPS core. Holds the fetch PC, the
// IF/ID register and the ID/EX register. Applies the hazard unit's stall and
// flush requests and the branch/jump redirection decided in decode. Three
// saturating performance counters track cycles, stall cycles and flush events.
//
// Parameters
//   RESET_PC  PC value loaded on reset
//   CNT_W     width of each performance counter
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   StallF, StallD, FlushE       hazard unit requests
//   PCSrcD, JumpD                redirect requests from decode
//   PCBranchD, PCJumpD           redirect targets
//   InstrF                       instruction fetched at PCF
//   PCF                          fetch PC
//   InstrD, PCPlus4D             IF/ID contents
//   *D control/operand inputs    decode stage values
//   *E outputs                   ID/EX contents
//   CycleCnt, StallCnt, FlushCnt performance counters
// ---------------------------------------------------------------------------
module fetch_decode_pipe #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic [31:0]      PCBranchD,
    input  logic [31:0]      PCJumpD,
    input  logic [31:0]      InstrF,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCPlus4D,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             MemWriteD,
    input  logic             ALUSrcD,
    input  logic             RegDstD,
    input  logic [2:0]       ALUControlD,
    input  logic [31:0]      RD1D,
    input  logic [31:0]      RD2D,
    input  logic [31:0]      SignImmD,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RdD,
    output logic             RegWriteE,
    output logic             MemtoRegE,
    output logic             MemWriteE,
    output logic             ALUSrcE,
    output logic             RegDstE,
    output logic [2:0]       ALUControlE,
    output logic [31:0]      RD1E,
    output logic [31:0]      RD2E,
    output logic [31:0]      SignImmE,
    output logic [4:0]       RsE,
    output logic [4:0]       RtE,
    output logic [4:0]       RdE,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    logic [31:0] pcplus4f;
    logic        redirect;
    logic        flush_event;

    // Sequential PC; the 32-bit add wraps naturally from 0xFFFF_FFFC to 0.
    assign pcplus4f = PCF + 32'd4;
    assign redirect = PCSrcD | JumpD;

    // A squash of IF/ID only counts when decode is not held, otherwise the
    // redirect is deferred and will be counted on the cycle it takes effect.
    assign flush_event = FlushE | (redirect & ~StallD);

    // Fetch PC: a jump outranks a branch if decode raises both.
    always_ff @(posedge clk) begin
        if (rst) begin
            PCF <= RESET_PC;
        end else if (!StallF) begin
            if (JumpD)
                PCF <= PCJumpD;
            else if (PCSrcD)
                PCF <= PCBranchD;
            else
                PCF <= pcplus4f;
        end
    end

    // IF/ID: a stall must win over a redirect because PCSrcD may be computed
    // from stale operands while decode waits on a hazard. Clearing to zero
    // turns the wrong-path instruction into sll $0,$0,0.
    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= 32'd0;
            PCPlus4D <= 32'd0;
        end else if (!StallD) begin
            if (redirect) begin
                InstrD   <= 32'd0;
                PCPlus4D <= 32'd0;
            end else begin
                InstrD   <= InstrF;
                PCPlus4D <= pcplus4f;
            end
        end
    end

    // ID/EX: never holds; a flush inserts an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            ALUControlE <= 3'd0;
            RD1E        <= 32'd0;
            RD2E        <= 32'd0;
            SignImmE    <= 32'd0;
            RsE         <= 5'd0;
            RtE         <= 5'd0;
            RdE         <= 5'd0;
        end else begin
            RegWriteE   <= RegWriteD;
            MemtoRegE   <= MemtoRegD;
            MemWriteE   <= MemWriteD;
            ALUSrcE     <= ALUSrcD;
            RegDstE     <= RegDstD;
            ALUControlE <= ALUControlD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            SignImmE    <= SignImmD;
            RsE         <= RsD;
            RtE         <= RtD;
            RdE         <= RdD;
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            CycleCnt <= '0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (CycleCnt != '1)
                CycleCnt <= CycleCnt + CNT_W'(1);
            if (StallD && (StallCnt != '1))
                StallCnt <= StallCnt + CNT_W'(1);
            if (flush_event && (FlushCnt != '1))
                FlushCnt <= FlushCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_pipe
//
// Directed testbench for fetch_decode_pipe. Each step drives the inputs,
// advances one rising edge and compares outputs against hand-computed values.
// Narrow counters are used so that saturation is reached in a short run.
// ---------------------------------------------------------------------------
module tb_fetch_decode_pipe;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam int          CW  = 4;

    logic          clk;
    logic          rst;
    logic          StallF, StallD, FlushE, PCSrcD, JumpD;
    logic [31:0]   PCBranchD, PCJumpD, InstrF;
    logic [31:0]   PCF, InstrD, PCPlus4D;
    logic          RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [2:0]    ALUControlD;
    logic [31:0]   RD1D, RD2D, SignImmD;
    logic [4:0]    RsD, RtD, RdD;
    logic          RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [2:0]    ALUControlE;
    logic [31:0]   RD1E, RD2E, SignImmE;
    logic [4:0]    RsE, RtE, RdE;
    logic [CW-1:0] CycleCnt, StallCnt, FlushCnt;

    int testsRun;
    int testsFailed;

    fetch_decode_pipe #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .PCSrcD(PCSrcD), .JumpD(JumpD),
        .PCBranchD(PCBranchD), .PCJumpD(PCJumpD), .InstrF(InstrF),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .RsE(RsE), .RtE(RtE), .RdE(RdE),
        .CycleCnt(CycleCnt), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle so outputs are sampled off the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic checkCounters(input string tag, input int cyc, input int stl, input int fls);
        checkOutput({tag, " CycleCnt"}, 32'(CycleCnt), cyc);
        checkOutput({tag, " StallCnt"}, 32'(StallCnt), stl);
        checkOutput({tag, " FlushCnt"}, 32'(FlushCnt), fls);
    endtask

    // Directed sequence; expected values derived by hand from the behaviour.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst = 1'b1;
        StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
        PCBranchD = 32'd0; PCJumpD = 32'd0; InstrF = 32'hCAFE_F00D;
        RegWriteD = 1'b1; MemtoRegD = 1'b1; MemWriteD = 1'b1; ALUSrcD = 1'b1; RegDstD = 1'b1;
        ALUControlD = 3'd7; RD1D = 32'hDEAD_BEEF; RD2D = 32'hDEAD_BEEF; SignImmD = 32'hDEAD_BEEF;
        RsD = 5'd1; RtD = 5'd2; RdD = 5'd3;

        // Reset with live inputs present.
        applyStimulus();
        applyStimulus();
        checkOutput("reset PCF", PCF, RPC);
        checkOutput("reset InstrD", InstrD, 32'd0);
        checkOutput("reset PCPlus4D", PCPlus4D, 32'd0);
        checkOutput("reset RD1E", RD1E, 32'd0);
        checkOutput("reset RegWriteE", 32'(RegWriteE), 32'd0);
        checkOutput("reset RdE", 32'(RdE), 32'd0);
        checkCounters("reset", 0, 0, 0);

        // Normal sequential fetch.
        rst = 1'b0;
        RegWriteD = 1'b0; MemtoRegD = 1'b0; MemWriteD = 1'b0; ALUSrcD = 1'b0; RegDstD = 1'b0;
        ALUControlD = 3'd0; RD1D = 32'd0; RD2D = 32'd0; SignImmD = 32'd0;
        RsD = 5'd0; RtD = 5'd0; RdD = 5'd0;
        InstrF = 32'h1111_1111;
        applyStimulus();
        checkOutput("seq1 PCF", PCF, 32'h0040_0004);
        checkOutput("seq1 InstrD", InstrD, 32'h1111_1111);
        checkOutput("seq1 PCPlus4D", PCPlus4D, 32'h0040_0004);

        InstrF = 32'h2222_2222;
        RegWriteD = 1'b1; ALUControlD = 3'd5; RD1D = 32'hAAAA_5555; RsD = 5'd3; RdD = 5'd31;
        applyStimulus();
        checkOutput("seq2 PCF", PCF, 32'h0040_0008);
        checkOutput("seq2 InstrD", InstrD, 32'h2222_2222);
        checkOutput("seq2 RegWriteE", 32'(RegWriteE), 32'd1);
        checkOutput("seq2 ALUControlE", 32'(ALUControlE), 32'd5);
        checkOutput("seq2 RD1E", RD1E, 32'hAAAA_5555);
        checkOutput("seq2 RdE", 32'(RdE), 32'd31);

        InstrF = 32'h3333_3333;
        RegWriteD = 1'b0; MemtoRegD = 1'b1; RD1D = 32'h1234_5678;
        applyStimulus();
        checkOutput("seq3 PCF", PCF, 32'h0040_000C);
        checkOutput("seq3 InstrD", InstrD, 32'h3333_3333);
        checkOutput("seq3 MemtoRegE", 32'(MemtoRegE), 32'd1);
        checkOutput("seq3 RD1E", RD1E, 32'h1234_5678);
        checkCounters("seq3", 3, 0, 0);

        // Load-use stall with bubble.
        InstrF = 32'h4444_4444;
        StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
        applyStimulus();
        checkOutput("ldu PCF", PCF, 32'h0040_000C);
        checkOutput("ldu InstrD", InstrD, 32'h3333_3333);
        checkOutput("ldu PCPlus4D", PCPlus4D, 32'h0040_000C);
        checkOutput("ldu RD1E", RD1E, 32'd0);
        checkOutput("ldu MemtoRegE", 32'(MemtoRegE), 32'd0);
        checkCounters("ldu", 4, 1, 1);

        StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0;
        applyStimulus();
        checkOutput("ldu resume PCF", PCF, 32'h0040_0010);
        checkOutput("ldu resume InstrD", InstrD, 32'h4444_4444);
        checkOutput("ldu resume RD1E", RD1E, 32'h1234_5678);
        checkCounters("ldu resume", 5, 1, 1);

        // Taken branch squashes the wrong-path instruction.
        InstrF = 32'h5555_5555; PCSrcD = 1'b1; PCBranchD = 32'h0000_0100;
        applyStimulus();
        checkOutput("br PCF", PCF, 32'h0000_0100);
        checkOutput("br InstrD", InstrD, 32'd0);
        checkOutput("br PCPlus4D", PCPlus4D, 32'd0);
        checkCounters("br", 6, 1, 2);

        PCSrcD = 1'b0; InstrF = 32'h6666_6666;
        applyStimulus();
        checkOutput("post br PCF", PCF, 32'h0000_0104);
        checkOutput("post br InstrD", InstrD, 32'h6666_6666);

        // Branch while stalled: no redirect, no flush counted.
        InstrF = 32'h7777_7777; PCSrcD = 1'b1; PCBranchD = 32'h0000_0200;
        StallF = 1'b1; StallD = 1'b1;
        applyStimulus();
        checkOutput("brstall PCF", PCF, 32'h0000_0104);
        checkOutput("brstall InstrD", InstrD, 32'h6666_6666);
        checkOutput("brstall PCPlus4D", PCPlus4D, 32'h0000_0104);
        checkCounters("brstall", 8, 2, 2);

        StallF = 1'b0; StallD = 1'b0;
        applyStimulus();
        checkOutput("brrel PCF", PCF, 32'h0000_0200);
        checkOutput("brrel InstrD", InstrD, 32'd0);
        checkCounters("brrel", 9, 2, 3);

        // Jump outranks branch; land on the last word.
        JumpD = 1'b1; PCSrcD = 1'b1; PCJumpD = 32'hFFFF_FFFC; PCBranchD = 32'h0000_0300;
        applyStimulus();
        checkOutput("jmp+br PCF", PCF, 32'hFFFF_FFFC);
        checkOutput("jmp+br InstrD", InstrD, 32'd0);
        checkCounters("jmp+br", 10, 2, 4);

        // Wrap from 0xFFFF_FFFC to 0.
        JumpD = 1'b0; PCSrcD = 1'b0; InstrF = 32'h8888_8888;
        applyStimulus();
        checkOutput("wrap PCF", PCF, 32'd0);
        checkOutput("wrap InstrD", InstrD, 32'h8888_8888);
        checkOutput("wrap PCPlus4D", PCPlus4D, 32'd0);

        // Jump held off by a stall, taken once released.
        StallF = 1'b1; StallD = 1'b1; JumpD = 1'b1; PCJumpD = 32'h0000_0500; InstrF = 32'h9999_9999;
        applyStimulus();
        checkOutput("jstall PCF", PCF, 32'd0);
        checkOutput("jstall InstrD", InstrD, 32'h8888_8888);
        checkCounters("jstall", 12, 3, 4);

        StallF = 1'b0; StallD = 1'b0;
        applyStimulus();
        checkOutput("jrel PCF", PCF, 32'h0000_0500);
        checkOutput("jrel InstrD", InstrD, 32'd0);
        checkCounters("jrel", 13, 3, 5);

        // Flush and redirect together count once.
        FlushE = 1'b1; PCJumpD = 32'h0000_0600;
        applyStimulus();
        checkOutput("jf PCF", PCF, 32'h0000_0600);
        checkOutput("jf RD1E", RD1E, 32'd0);
        checkCounters("jf", 14, 3, 6);

        // Cycle counter reaches all-ones, then saturates.
        FlushE = 1'b0; JumpD = 1'b0; InstrF = 32'hAAAA_0000;
        applyStimulus();
        checkOutput("sat1 PCF", PCF, 32'h0000_0604);
        checkOutput("sat1 RD1E", RD1E, 32'h1234_5678);
        checkCounters("sat1", 15, 3, 6);

        applyStimulus();
        checkOutput("sat2 PCF", PCF, 32'h0000_0608);
        checkCounters("sat2", 15, 3, 6);

        // Reset mid-stream overrides a pending stall.
        rst = 1'b1; StallF = 1'b1; FlushE = 1'b0;
        applyStimulus();
        checkOutput("midrst PCF", PCF, RPC);
        checkOutput("midrst InstrD", InstrD, 32'd0);
        checkOutput("midrst PCPlus4D", PCPlus4D, 32'd0);
        checkOutput("midrst RD1E", RD1E, 32'd0);
        checkOutput("midrst MemtoRegE", 32'(MemtoRegE), 32'd0);
        checkCounters("midrst", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
